// File: rtl/mux32_pkg.sv
// mux32_pkg: shared width, word type and skid-stage state encoding for the mux32 output stage.
package mux32_pkg;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_t;
    typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/mux32_skid_reg.sv
// mux32_skid_reg: registered two-entry skid stage behind the 32-bit operand mux.
// Optional fault injection on captured words is enabled with `define FAULT_INJECT_EN.
module mux32_skid_reg
    import mux32_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef FAULT_INJECT_EN
    , parameter int FCNT_W = 8
`endif
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
`ifdef FAULT_INJECT_EN
    input  logic              f_i,
    input  logic [DATA_W-1:0] fault_mask_i,
    output logic [FCNT_W-1:0] fault_cnt_o,
`endif
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
);
    skid_state_t       state, state_nxt;
    logic [DATA_W-1:0] head, skid, wdata;
    logic              accept, pop, load_head, load_skid;

    // ready decodes straight from the state flop, so consumer stalls never reach upstream combinationally
    assign in_ready_o  = state != ST_FULL;
    assign out_valid_o = state != ST_EMPTY;
    assign out_data_o  = head;
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

`ifdef FAULT_INJECT_EN
    logic [FCNT_W-1:0] fcnt;
    assign wdata       = f_i ? in_data_i ^ fault_mask_i : in_data_i;
    assign fault_cnt_o = fcnt;
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i)
            fcnt <= '0;
        else if (accept && f_i && !flush_i && fcnt != '1)
            fcnt <= fcnt + 1'b1;
`else
    assign wdata = in_data_i;
`endif

    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        case (state)
            ST_EMPTY: if (accept) begin
                state_nxt = ST_ONE;
                load_head = 1'b1;
            end
            ST_ONE: if (accept) begin
                state_nxt = pop ? ST_ONE : ST_FULL;
                load_head = pop;
                load_skid = !pop;
            end else if (pop) begin
                state_nxt = ST_EMPTY;
            end
            ST_FULL: if (pop) state_nxt = ST_ONE;
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_nxt = ST_EMPTY;
            load_head = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            state <= ST_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            if (load_head)
                head <= wdata;
            else if (state == ST_FULL && pop)
                head <= skid;
            if (load_skid)
                skid <= wdata;
        end
endmodule

// File: tb/tb_mux32_skid_reg.sv
// tb_mux32_skid_reg: directed and random stimulus against a queue-based reference of the skid stage.
module tb_mux32_skid_reg;
    import mux32_pkg::*;

    logic  clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic  in_ready, out_valid;
    word_t in_data = '0, out_data;
    word_t q[$];
    int    checks = 0, errors = 0;
`ifdef FAULT_INJECT_EN
    logic       f = 1'b0;
    word_t      fmask = '0;
    logic [7:0] fcnt;
    int         fc_m = 0;
`endif

    always #5 clk = ~clk;

    mux32_skid_reg dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
`ifdef FAULT_INJECT_EN
        .f_i         (f),
        .fault_mask_i(fmask),
        .fault_cnt_o (fcnt),
`endif
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) check("out_data", out_data, q[0]);
`ifdef FAULT_INJECT_EN
        check("fault_cnt", 32'(fcnt), 32'(fc_m));
`endif
    endtask

    // the model is a FIFO of at most two words: pop first, then flush wipes or accept appends
    task automatic step();
        bit    acc, pp;
        word_t w;
        @(posedge clk);
        acc = in_valid && q.size() < 2;
        pp  = q.size() > 0 && out_ready;
        w   = in_data;
`ifdef FAULT_INJECT_EN
        if (f) w = w ^ fmask;
        if (acc && f && !flush && fc_m < 255) fc_m++;
`endif
        if (pp) void'(q.pop_front());
        if (flush) q.delete();
        else if (acc) q.push_back(w);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input word_t d, input logic r, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = fl;
        step();
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) drive(1'b1, word_t'(i), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        drive(1'b1, 32'hAAAA5555, 1'b0, 1'b0);
        drive(1'b1, 32'h12345678, 1'b0, 1'b0);
        check("full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        check("full_hold", out_data, 32'hAAAA5555);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("drain_second", out_data, 32'h12345678);
        drive(1'b0, '0, 1'b1, 1'b0);
        check("drain_empty", 32'(out_valid), 32'd0);

        drive(1'b1, 32'h11111111, 1'b0, 1'b0);
        drive(1'b1, 32'h22222222, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        check("post_flush", out_data, 32'hCAFEF00D);
        drive(1'b0, '0, 1'b1, 1'b0);

        drive(1'b1, 32'h33333333, 1'b0, 1'b0);
        drive(1'b1, 32'h44444444, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
`ifdef FAULT_INJECT_EN
        fc_m = 0;
`endif
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_data", out_data, 32'd0);
        check("async_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        drive(1'b1, 32'h00000055, 1'b1, 1'b0);
        check("post_rst", out_data, 32'h00000055);
        drive(1'b0, '0, 1'b1, 1'b0);

`ifdef FAULT_INJECT_EN
        f     = 1'b1;
        fmask = 32'h00000001;
        drive(1'b1, 32'h0000FFFF, 1'b1, 1'b0);
        check("fault_data", out_data, 32'h0000FFFE);
        check("fault_one", 32'(fcnt), 32'd1);
        for (int i = 0; i < 300; i++) drive(1'b1, $urandom, 1'b1, 1'b0);
        check("fault_sat", 32'(fcnt), 32'hFF);
        f = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 2000; i++) begin
            if (!(in_valid && q.size() >= 2)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
`ifdef FAULT_INJECT_EN
                f     = ($urandom_range(0, 7) == 0);
                fmask = $urandom;
`endif
            end
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
